// File: rtl/video_timing_pkg.sv
// Purpose: shared video timing constants and the capture FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_timing_pkg;

  // 640x480 geometry carried inside an 800x500 raster.
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 500;

  // Widths of the coordinate outputs.
  localparam int XW = 10;
  localparam int YW = 9;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: registers a bundle of sync lines and exposes the previous sample
//          plus rise/fall strobes. Latency: strobes are combinational on the
//          current input against a 1-cycle-old sample. Backpressure: none.
// Ports: clk, rst_n, sync_in[W], sync_prev[W], sync_rise[W], sync_fall[W].
module sync_edge_detect #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sync_in,
  output logic [W-1:0] sync_prev,
  output logic [W-1:0] sync_rise,
  output logic [W-1:0] sync_fall
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_prev <= '0;
    end else begin
      sync_prev <= sync_in;
    end
  end

  assign sync_rise = sync_in & ~sync_prev;
  assign sync_fall = ~sync_in & sync_prev;

endmodule

// File: rtl/video_sync_capture.sv
// Purpose: recovers pixel coordinates from hsyn/vsyn-qualified luma, emits
//          linear frame-buffer writes and flags line/frame geometry errors.
// Latency: 1 cycle from sampled input to wr_*/pulse outputs. Backpressure:
//          none, the memory must take one write per cycle.
// Ports: clk, rst_n, hsyn, vsyn, pix_in -> wr_en, wr_addr, wr_data, x_cnt,
//        y_cnt, frame_done, frame_ok, err_line, err_frame.
module video_sync_capture #(
  parameter int H_ACTIVE = video_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE = video_timing_pkg::V_ACTIVE,
  parameter int DW       = 8,
  parameter int AW       = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsyn,
  input  logic          vsyn,
  input  logic [DW-1:0] pix_in,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [9:0]    x_cnt,
  output logic [8:0]    y_cnt,
  output logic          frame_done,
  output logic          frame_ok,
  output logic          err_line,
  output logic          err_frame
);
  import video_timing_pkg::*;

  localparam logic [XW-1:0] X_MAX     = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_MAX     = YW'(V_ACTIVE);
  // line_base is one bit wider: H*V may equal 2^AW exactly.
  localparam logic [AW:0]   BASE_STEP = (AW+1)'(H_ACTIVE);
  localparam logic [AW:0]   BASE_MAX  = (AW+1)'(H_ACTIVE * V_ACTIVE);
  localparam logic [AW:0]   BASE_LAST = BASE_MAX - BASE_STEP;

  // Sync edge detection, bit 1 = vsyn, bit 0 = hsyn.
  logic [1:0] sync_prev, sync_rise, sync_fall;

  sync_edge_detect #(.W(2)) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_in   ({vsyn, hsyn}),
    .sync_prev (sync_prev),
    .sync_rise (sync_rise),
    .sync_fall (sync_fall)
  );

  // Previous-sample and rise taps are not needed by this block.
  logic unused_taps;
  assign unused_taps = ^{sync_prev, sync_rise};

  cap_state_t state_q, state_d;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW:0]   base_q, base_d;
  logic          line_xs_q, line_xs_d;    // excess pixel already flagged on this line
  logic          frame_xs_q, frame_xs_d;  // excess line already flagged in this frame
  logic          sticky_q, sticky_d;      // any error seen in this frame

  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [DW-1:0] wr_data_d;
  logic          frame_done_d, frame_ok_d, err_line_d, err_frame_d;

  logic start, active, line_end, frame_end;

  assign start     = (state_q == IDLE) && vsyn;
  assign active    = (state_q == FRAME) || start;
  assign line_end  = (state_q == FRAME) && sync_fall[0];
  assign frame_end = (state_q == FRAME) && sync_fall[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (!vsyn)    state_d = IDLE;
      IDLE:    if (vsyn)     state_d = FRAME;
      FRAME:   if (frame_end) state_d = IDLE;
      default:               state_d = SYNC;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    logic [XW-1:0] x_b;
    logic [YW-1:0] y_b;
    logic [AW:0]   base_b;
    logic          line_xs_b, frame_xs_b, sticky_b;
    logic [AW:0]   addr_sum;

    // The cycle that opens a frame works from cleared counters.
    x_b        = start ? '0   : x_q;
    y_b        = start ? '0   : y_q;
    base_b     = start ? '0   : base_q;
    line_xs_b  = start ? 1'b0 : line_xs_q;
    frame_xs_b = start ? 1'b0 : frame_xs_q;
    sticky_b   = start ? 1'b0 : sticky_q;

    addr_sum     = base_b + (AW+1)'(x_b);

    x_d          = x_b;
    y_d          = y_b;
    base_d       = base_b;
    line_xs_d    = line_xs_b;
    frame_xs_d   = frame_xs_b;
    sticky_d     = sticky_b;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    err_line_d   = 1'b0;
    err_frame_d  = 1'b0;

    if (active) begin
      if (hsyn && vsyn) begin
        if (x_b >= X_MAX) begin
          if (!line_xs_b) begin
            err_line_d = 1'b1;
            line_xs_d  = 1'b1;
          end
        end else if (y_b >= Y_MAX) begin
          // x still advances so the line-length check stays meaningful.
          if (!frame_xs_b) begin
            err_frame_d = 1'b1;
            frame_xs_d  = 1'b1;
          end
          x_d = x_b + 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_sum[AW-1:0];
          wr_data_d = pix_in;
          x_d       = x_b + 1'b1;
        end
      end

      // Line end is resolved before frame end so a joint fall sees the new y.
      if (line_end) begin
        if (x_b < X_MAX) err_line_d = 1'b1;
        x_d       = '0;
        y_d       = (y_b == '1) ? y_b : y_b + 1'b1;
        base_d    = (base_b >= BASE_LAST) ? BASE_MAX : base_b + BASE_STEP;
        line_xs_d = 1'b0;
      end

      if (frame_end) begin
        frame_done_d = 1'b1;
        frame_ok_d   = (y_d == Y_MAX) && !(sticky_b || err_line_d || err_frame_d);
        if (y_d != Y_MAX) err_frame_d = 1'b1;
      end

      sticky_d = sticky_b | err_line_d | err_frame_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      line_xs_q  <= 1'b0;
      frame_xs_q <= 1'b0;
      sticky_q   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      line_xs_q  <= line_xs_d;
      frame_xs_q <= frame_xs_d;
      sticky_q   <= sticky_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      frame_done <= frame_done_d;
      frame_ok   <= frame_ok_d;
      err_line   <= err_line_d;
      err_frame  <= err_frame_d;
    end
  end

  assign x_cnt = x_q;
  assign y_cnt = y_q;

endmodule

// File: tb/tb_video_sync_capture.sv
// Purpose: self-checking bench for video_sync_capture on an 8x4 geometry.
// Latency: expects outputs one cycle after each input slot.
// Backpressure: none, one slot per clock.
module tb_video_sync_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hsyn = 1'b0;
  logic          vsyn = 1'b0;
  logic [DW-1:0] pix_in = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [9:0]    x_cnt;
  logic [8:0]    y_cnt;
  logic          frame_done, frame_ok, err_line, err_frame;

  video_sync_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsyn       (hsyn),
    .vsyn       (vsyn),
    .pix_in     (pix_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .x_cnt      (x_cnt),
    .y_cnt      (y_cnt),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_line   (err_line),
    .err_frame  (err_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          el;
    logic          ef;
    logic          fd;
    logic          fok;
    logic [8:0]    y;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  bit live = 1'b1;   // 0 while the DUT is expected to ignore the current frame
  int lens[8];       // pixels per line for the next frame

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_cleared(input string where);
    check_val({where, " wr_en"},      32'(wr_en),      32'd0);
    check_val({where, " wr_addr"},    32'(wr_addr),    32'd0);
    check_val({where, " wr_data"},    32'(wr_data),    32'd0);
    check_val({where, " x_cnt"},      32'(x_cnt),      32'd0);
    check_val({where, " y_cnt"},      32'(y_cnt),      32'd0);
    check_val({where, " frame_done"}, 32'(frame_done), 32'd0);
    check_val({where, " frame_ok"},   32'(frame_ok),   32'd0);
    check_val({where, " err_line"},   32'(err_line),   32'd0);
    check_val({where, " err_frame"},  32'(err_frame),  32'd0);
  endtask

  // Apply one input slot, then check the outputs it produces.
  task automatic step(input logic h, input logic v, input int p, input exp_t e);
    hsyn   = h;
    vsyn   = v;
    pix_in = p[DW-1:0];
    @(posedge clk);
    #1;
    check_val("wr_en", 32'(wr_en), 32'(e.wr));
    if (e.wr) begin
      check_val("wr_addr", 32'(wr_addr), 32'(e.addr));
      check_val("wr_data", 32'(wr_data), 32'(e.data));
    end
    check_val("err_line",   32'(err_line),   32'(e.el));
    check_val("err_frame",  32'(err_frame),  32'(e.ef));
    check_val("frame_done", 32'(frame_done), 32'(e.fd));
    if (e.fd) begin
      check_val("frame_ok", 32'(frame_ok), 32'(e.fok));
      check_val("y_cnt",    32'(y_cnt),    32'(e.y));
    end
  endtask

  // One frame of nlines lines with lengths lens[]; expectations follow the
  // frame geometry rules directly (address = line*H + column).
  task automatic send_frame(input int nlines, input bit simul, input int abort_line,
                            input bit data_is_addr);
    exp_t e;
    bit   err_any;
    int   d, nb, g;
    err_any = (nlines != V);
    for (int l = 0; l < nlines; l++) if (lens[l] != H) err_any = 1'b1;

    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        if (l == abort_line && p == 3) begin
          rst_n = 1'b0;
          #1;
          check_cleared("mid_reset");
          live = 1'b0;
        end
        d = data_is_addr ? (l * H + p) : int'($urandom_range(0, 255));
        e = '0;
        if (live) begin
          if (p < H && l < V) begin
            e.wr   = 1'b1;
            e.addr = AW'(l * H + p);
            e.data = d[DW-1:0];
          end
          if (p == H) e.el = 1'b1;
          if (l == V && p == 0) e.ef = 1'b1;
        end
        step(1'b1, 1'b1, d, e);
        if (l == abort_line && p == 3) rst_n = 1'b1;
      end
      if (!(simul && l == nlines - 1)) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          e = '0;
          if (b == 0 && live && lens[l] < H) e.el = 1'b1;
          step(1'b0, 1'b1, 0, e);
        end
      end
    end

    g = $urandom_range(1, 3);
    for (int b = 0; b < g; b++) begin
      e = '0;
      if (b == 0 && live) begin
        e.fd  = 1'b1;
        e.fok = !err_any;
        e.ef  = (nlines != V);
        e.y   = 9'(nlines);
        if (simul && lens[nlines-1] < H) e.el = 1'b1;
      end
      step(1'b0, 1'b0, 0, e);
    end
  endtask

  task automatic set_lens(input int a, input int b, input int c, input int d2, input int e2);
    lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d2; lens[4] = e2;
    lens[5] = H; lens[6] = H; lens[7] = H;
  endtask

  initial begin
    exp_t z;
    int   pick, nl;
    z = '0;
    #1;
    check_cleared("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, z);

    set_lens(H, H, H, H, H);   send_frame(4, 1'b0, -1, 1'b1);  // nominal
    set_lens(H, 6, H, H, H);   send_frame(4, 1'b0, -1, 1'b0);  // short line
    set_lens(10, H, H, H, H);  send_frame(4, 1'b0, -1, 1'b0);  // long line
    set_lens(H, H, H, H, H);   send_frame(3, 1'b0, -1, 1'b0);  // short frame
    set_lens(H, H, H, H, H);   send_frame(5, 1'b0, -1, 1'b0);  // long frame
    set_lens(H, H, H, H, H);   send_frame(4, 1'b1, -1, 1'b1);  // joint sync fall
    set_lens(H, H, 6, H, H);   send_frame(4, 1'b1, -1, 1'b0);  // joint fall, short last line
    set_lens(H, H, H, H, H);   send_frame(4, 1'b0, 2, 1'b0);   // reset mid-frame
    live = 1'b1;
    set_lens(H, H, H, H, H);   send_frame(4, 1'b0, -1, 1'b1);  // next frame from addr 0

    for (int f = 0; f < 30; f++) begin
      for (int l = 0; l < 8; l++)
        lens[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 10)) : H;
      pick = $urandom_range(0, 5);
      nl   = (pick == 0) ? 3 : (pick == 1) ? 5 : 4;
      send_frame(nl, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
